// File: rtl/aes128_iter_seq_if.sv
// Block source/sink handshake bundle for aes128_iter_seq.
// master: the block source plus the ciphertext sink; slave: the cipher core.
interface aes128_iter_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] o;

  modport master (
    output in_valid, data, key, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, data, key, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/aes128_iter_seq.sv
// Iterative AES-128 encryptor: one round datapath, on-the-fly key expansion.
// Optional macro AES128_ITER_SEQ_OVERLAP_EN: accept next block during output.
module aes128_iter_seq #(
  parameter int ROUNDS = 10
) (
  input  logic clk,
  input  logic rst,
  aes128_iter_seq_if.slave bus,
  output logic       busy,
  output logic [3:0] round
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  // Stored high-to-low, so entry x lives at index ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t         cur, nxt;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [127:0] nk;
  logic [127:0] nstate;
  logic         load;
  logic         step;
  logic         in_ready;
  logic         out_valid;

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] next_key(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = subw({w3[23:0], w3[31:24]}) ^
         {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte i sits at row i%4, column i/4.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] =
          s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] mix_cols(
    input logic [127:0] s
  );
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  always_comb begin
    logic [127:0] sr;
    nk = next_key(rk_reg, rcon(round));
    sr = shift_rows(sub_bytes(state_reg));
    // Final round skips mixColumns.
    if (round == LAST)
      nstate = sr ^ nk;
    else
      nstate = mix_cols(sr) ^ nk;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cur <= IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (cur)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load = 1'b1;
          nxt  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (round == LAST)
          nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef AES128_ITER_SEQ_OVERLAP_EN
        in_ready = bus.out_ready;
        load     = bus.out_ready & bus.in_valid;
        if (bus.out_ready)
          nxt = bus.in_valid ? RUN : IDLE;
`else
        if (bus.out_ready)
          nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      rk_reg    <= '0;
      round     <= 4'd0;
    end else if (load) begin
      state_reg <= bus.data ^ bus.key;
      rk_reg    <= bus.key;
      round     <= 4'd1;
    end else if (step) begin
      state_reg <= nstate;
      rk_reg    <= nk;
      round     <= (round == LAST) ?
                   4'd0 : round + 4'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.o         = state_reg;

endmodule

// File: tb/tb_aes128_iter_seq.sv
// Scoreboard bench for aes128_iter_seq against a byte-array AES-128 model.
// Expected spacing follows AES128_ITER_SEQ_OVERLAP_EN when defined.
module tb_aes128_iter_seq;

  localparam int R = 10;
`ifdef AES128_ITER_SEQ_OVERLAP_EN
  localparam int SPACING = 11;
`else
  localparam int SPACING = 12;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] round;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [127:0] sb[$];
  int           acc_q[$];
  int           acc_edge = 0;
  logic         prev_ov = 1'b0;
  logic         prev_or = 1'b0;
  logic [127:0] prev_o = '0;
  logic [7:0]   stab[256];

  localparam logic [127:0] C1_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_O = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_D  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_O  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_S1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] B_K1 = 128'ha0fafe1788542cb123a339392a6c7605;

  aes128_iter_seq_if bus ();

  aes128_iter_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .round (round)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse, then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      stab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] d,
                                           input logic [127:0] k);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {stab[tmp[31:24]], stab[tmp[23:16]],
               stab[tmp[15:8]], stab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = d[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = 1; rd <= R; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = stab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rd < R) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
        for (int r = 0; r < 4; r++)
          s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept tracker and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(aes_ref(bus.data, bus.key));
        acc_edge = cyc + 1;
        acc_q.push_back(cyc + 1);
      end
      if (bus.out_valid && !prev_ov)
        chk("latency", 128'(cyc - acc_edge), 128'(R));
      if (prev_ov && !prev_or) begin
        chk("ov_hold", {127'd0, bus.out_valid}, 128'd1);
        chk("o_hold", bus.o, prev_o);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0)
          fail("spurious ciphertext");
        else
          chk("ciphertext", bus.o, sb.pop_front());
      end
      prev_ov = bus.out_valid;
      prev_or = bus.out_ready;
      prev_o  = bus.o;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k);
    bit ok;
    ok = 1'b0;
    bus.data = d;
    bus.key = k;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) fail("accept timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data = rnd128();
    bus.key = rnd128();
  endtask

  task automatic drain(input bit rnd_or);
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      bus.out_ready = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) fail("drain timeout");
    chk("in_ready_after", {127'd0, bus.in_ready}, 128'd1);
    chk("ov_after", {127'd0, bus.out_valid}, 128'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_ov();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) fail("out_valid timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    int n0;
    bit ok;
    build_sbox();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.data = '0;
    bus.key = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("rst out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst busy", {127'd0, busy}, 128'd0);
    chk("rst round", {124'd0, round}, 128'd0);
    chk("rst o", bus.o, 128'd0);

    chk("model C.1", aes_ref(C1_D, C1_K), C1_O);
    chk("model App.B", aes_ref(B_D, B_K), B_O);

    bus.out_ready = 1'b1;
    send(C1_D, C1_K);
    drain(1'b0);

    send(B_D, B_K);
    @(posedge clk);
    #1;
    chk("probe state", dut.state_reg, B_S1);
    chk("probe rk", dut.rk_reg, B_K1);
    chk("probe round", {124'd0, round}, 128'd2);
    drain(1'b0);

    bus.out_ready = 1'b0;
    send(rnd128(), rnd128());
    wait_ov();
    held = bus.o;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.data = rnd128();
      bus.key = rnd128();
      @(negedge clk);
      chk("bp o", bus.o, held);
      chk("bp in_ready", {127'd0, bus.in_ready}, 128'd0);
    end
    @(posedge clk);
    #1;
    drain(1'b0);
    send(rnd128(), rnd128());
    drain(1'b0);

    send(rnd128(), rnd128());
    for (int i = 1; i <= R; i++) begin
      bus.data = rnd128();
      bus.key = rnd128();
      bus.in_valid = 1'(i % 2);
      @(negedge clk);
      chk("run round", {124'd0, round}, 128'(i));
      chk("run busy", {127'd0, busy}, 128'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain(1'b0);

    send(rnd128(), rnd128());
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (round == 4'd5) ok = 1'b1;
    end
    if (!ok) fail("round 5 timeout");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("mid rst out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("mid rst round", {124'd0, round}, 128'd0);
    send(C1_D, C1_K);
    drain(1'b0);

    n0 = acc_q.size();
    bus.out_ready = 1'b1;
    bus.data = C1_D;
    bus.key = C1_K;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.data = B_D;
    bus.key = B_K;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (acc_q.size() != n0 + 2)
      fail("back-to-back accepts");
    else
      chk("spacing", 128'(acc_q[n0+1] - acc_q[n0]), 128'(SPACING));
    drain(1'b0);

    for (int b = 0; b < 8; b++) begin
      send(rnd128(), rnd128());
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
